// File: rtl/set_assoc_cache.sv
// set_assoc_cache: N-way set-associative cache with its own miss handling.
// Owns line fill from memory, true-LRU replacement and write-through stores
// (no write-allocate). Usable as instruction or data cache.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_*             request channel; accepted when req_valid & req_ready
//   rsp_*             one-cycle completion pulse with load data and hit flag
//   mem_*             word-wide memory command/return channel; returns
//                     arrive in issue order, mem_ready accepts a command
//   stat_hits/misses  hit/miss counters, present only with CACHE_STATS_EN
//
// Optional feature macro: CACHE_STATS_EN (adds saturating 32-bit counters).
module set_assoc_cache #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int WAYS           = 2,
    parameter int SETS           = 64,
    parameter int WORDS_PER_LINE = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_hit,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses
`endif
);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 1 - OFF_W - IDX_W;
    // A single-way cache still needs a 1-bit way/age field; it stays 0.
    localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOOKUP = 3'd1;
    localparam logic [2:0] FILL   = 3'd2;
    localparam logic [2:0] WRITE  = 3'd3;
    localparam logic [2:0] RESP   = 3'd4;

    typedef logic [WAYS-1:0][AGE_W-1:0] ages_t;

    // Reset value of the LRU ages: way w starts with age w.
    function automatic logic [SETS-1:0][WAYS-1:0][AGE_W-1:0] age_init();
        logic [SETS-1:0][WAYS-1:0][AGE_W-1:0] r;
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                r[s][w] = AGE_W'(w);
            end
        end
        return r;
    endfunction

    // Make 'way' most recently used; younger ways age by one.
    function automatic ages_t lru_touch(input ages_t ages, input logic [AGE_W-1:0] way);
        ages_t r;
        r = ages;
        for (int i = 0; i < WAYS; i++) begin
            if (ages[i] < ages[way]) begin
                r[i] = ages[i] + AGE_W'(1);
            end
        end
        r[way] = '0;
        return r;
    endfunction

    logic [2:0]              state_r;
    logic                    req_ready_r, rsp_valid_r, rsp_hit_r;
    logic [DATA_W-1:0]       rsp_rdata_r, mem_wdata_r, wdata_r;
    logic                    mem_rd_en_r, mem_wr_en_r;
    logic [ADDR_W-1:0]       mem_addr_r, addr_r;
    logic                    write_r, hit_r;
    logic [AGE_W-1:0]        victim_r;
    logic [OFF_W-1:0]        issue_cnt_r, ret_cnt_r;

    logic [SETS-1:0][WAYS-1:0]             valid_r;
    logic [SETS-1:0][WAYS-1:0][AGE_W-1:0]  age_r;
    logic [WAYS-1:0][TAG_W-1:0]            tag_r  [SETS];
    logic [DATA_W-1:0]                     data_r [SETS][WAYS][WORDS_PER_LINE];

    logic [OFF_W-1:0] off_s;
    logic [IDX_W-1:0] idx_s;
    logic [TAG_W-1:0] tag_s;
    logic             hit_s, any_inv_s, last_ret_s;
    logic [AGE_W-1:0] hit_way_s, inv_way_s, lru_way_s, victim_s;

    assign off_s      = addr_r[OFF_W:1];
    assign idx_s      = addr_r[OFF_W+IDX_W:OFF_W+1];
    assign tag_s      = addr_r[ADDR_W-1:OFF_W+IDX_W+1];
    assign last_ret_s = (ret_cnt_r == OFF_W'(WORDS_PER_LINE - 1));

    // Tag compare and victim choice for the latched request's set.
    always_comb begin
        hit_s     = 1'b0;
        hit_way_s = '0;
        any_inv_s = 1'b0;
        inv_way_s = '0;
        lru_way_s = '0;
        // Scan downward so the lowest-index match/invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_r[idx_s][w] && (tag_r[idx_s][w] == tag_s)) begin
                hit_s     = 1'b1;
                hit_way_s = AGE_W'(w);
            end else begin
                hit_s     = hit_s;
            end
            if (!valid_r[idx_s][w]) begin
                any_inv_s = 1'b1;
                inv_way_s = AGE_W'(w);
            end else begin
                any_inv_s = any_inv_s;
            end
            if (age_r[idx_s][w] == AGE_W'(WAYS - 1)) begin
                lru_way_s = AGE_W'(w);
            end else begin
                lru_way_s = lru_way_s;
            end
        end
        if (any_inv_s) begin
            victim_s = inv_way_s;
        end else begin
            victim_s = lru_way_s;
        end
    end

    // Control FSM, per-line valid/LRU state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_hit_r   <= 1'b0;
            rsp_rdata_r <= '0;
            mem_rd_en_r <= 1'b0;
            mem_wr_en_r <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            addr_r      <= '0;
            wdata_r     <= '0;
            write_r     <= 1'b0;
            hit_r       <= 1'b0;
            victim_r    <= '0;
            issue_cnt_r <= '0;
            ret_cnt_r   <= '0;
            valid_r     <= '0;
            age_r       <= age_init();
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid && req_ready_r) begin
                        addr_r      <= req_addr;
                        wdata_r     <= req_wdata;
                        write_r     <= req_write;
                        req_ready_r <= 1'b0;
                        state_r     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    hit_r <= hit_s;
                    if (write_r) begin
                        if (hit_s) begin
                            age_r[idx_s] <= lru_touch(age_r[idx_s], hit_way_s);
                        end
                        mem_wr_en_r <= 1'b1;
                        mem_addr_r  <= addr_r;
                        mem_wdata_r <= wdata_r;
                        state_r     <= WRITE;
                    end else if (hit_s) begin
                        age_r[idx_s] <= lru_touch(age_r[idx_s], hit_way_s);
                        rsp_valid_r  <= 1'b1;
                        rsp_hit_r    <= 1'b1;
                        rsp_rdata_r  <= data_r[idx_s][hit_way_s][off_s];
                        state_r      <= RESP;
                    end else begin
                        // Victim is invalidated up front so a partially
                        // overwritten line can never hit.
                        victim_r                  <= victim_s;
                        valid_r[idx_s][victim_s]  <= 1'b0;
                        issue_cnt_r               <= '0;
                        ret_cnt_r                 <= '0;
                        mem_rd_en_r               <= 1'b1;
                        mem_addr_r                <= {tag_s, idx_s, {OFF_W{1'b0}}, 1'b0};
                        state_r                   <= FILL;
                    end
                end
                FILL: begin
                    if (mem_rd_en_r && mem_ready) begin
                        issue_cnt_r <= issue_cnt_r + OFF_W'(1);
                        if (issue_cnt_r == OFF_W'(WORDS_PER_LINE - 1)) begin
                            mem_rd_en_r <= 1'b0;
                            mem_addr_r  <= '0;
                        end else begin
                            mem_addr_r  <= mem_addr_r + ADDR_W'(2);
                        end
                    end
                    if (mem_rvalid) begin
                        ret_cnt_r <= ret_cnt_r + OFF_W'(1);
                        if (ret_cnt_r == off_s) begin
                            rsp_rdata_r <= mem_rdata;
                        end
                        if (last_ret_s) begin
                            valid_r[idx_s][victim_r] <= 1'b1;
                            age_r[idx_s] <= lru_touch(age_r[idx_s], victim_r);
                            rsp_valid_r  <= 1'b1;
                            rsp_hit_r    <= 1'b0;
                            state_r      <= RESP;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        mem_wr_en_r <= 1'b0;
                        mem_addr_r  <= '0;
                        mem_wdata_r <= '0;
                        rsp_valid_r <= 1'b1;
                        rsp_hit_r   <= hit_r;
                        rsp_rdata_r <= '0;
                        state_r     <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid_r <= 1'b0;
                    rsp_hit_r   <= 1'b0;
                    rsp_rdata_r <= '0;
                    req_ready_r <= 1'b1;
                    state_r     <= IDLE;
                end
                default: begin
                    mem_rd_en_r <= 1'b0;
                    mem_wr_en_r <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    req_ready_r <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (state_r == LOOKUP && write_r && hit_s) begin
            data_r[idx_s][hit_way_s][off_s] <= wdata_r;
        end else if (state_r == FILL && mem_rvalid) begin
            data_r[idx_s][victim_r][ret_cnt_r] <= mem_rdata;
            if (last_ret_s) begin
                tag_r[idx_s][victim_r] <= tag_s;
            end
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_hit   = rsp_hit_r;
    assign mem_rd_en = mem_rd_en_r;
    assign mem_wr_en = mem_wr_en_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

`ifdef CACHE_STATS_EN
    // Saturating hit/miss counters, stepped on each completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_hits   <= 32'd0;
            stat_misses <= 32'd0;
        end else if (rsp_valid_r) begin
            if (rsp_hit_r) begin
                if (stat_hits != 32'hFFFF_FFFF) stat_hits <= stat_hits + 32'd1;
            end else begin
                if (stat_misses != 32'hFFFF_FFFF) stat_misses <= stat_misses + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// Self-checking bench for set_assoc_cache (default parameters).
// Responses are checked by a scoreboard: each request pushes its expected
// {data, hit} and the monitor pops/compares on every rsp_valid pulse.
// Memory model: word at byte address A holds A until written.
module tb_set_assoc_cache;
    typedef struct {
        logic [15:0] data;
        logic        hit;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [15:0] req_addr = 16'h0000, req_wdata = 16'h0000;
    logic        req_ready, rsp_valid, rsp_hit, mem_rd_en, mem_wr_en;
    logic [15:0] rsp_rdata, mem_addr, mem_wdata;
    logic        mem_ready = 1'b1, mem_rvalid = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
`ifdef CACHE_STATS_EN
    logic [31:0] stat_hits, stat_misses;
`endif

    int checks = 0, failures = 0;
    int rd_count = 0, wr_count = 0, ret_count = 0;
    logic [15:0] last_wr_addr = 16'h0000, last_wr_data = 16'h0000;
    logic [15:0] mem [0:32767];
    logic [15:0] rq [$];
    logic [15:0] rd_log [$];
    exp_t        exp_q [$];

    set_assoc_cache dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_hit(rsp_hit),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid)
`ifdef CACHE_STATS_EN
        , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: command acceptance at the clock edge.
    always @(posedge clk) begin
        if (!rst) begin
            if (mem_rd_en && mem_wr_en) begin
                checks++; failures++;
                $display("FAIL mem_excl rd_en=%b wr_en=%b required not both", mem_rd_en, mem_wr_en);
            end
            if (mem_rd_en && mem_ready) begin
                rq.push_back(mem_addr);
                rd_log.push_back(mem_addr);
                rd_count++;
            end
            if (mem_wr_en && mem_ready) begin
                mem[mem_addr[15:1]] = mem_wdata;
                last_wr_addr = mem_addr;
                last_wr_data = mem_wdata;
                wr_count++;
            end
            if (mem_rvalid) ret_count++;
        end
    end

    // Memory model: one in-order return per cycle, driven away from the edge.
    always @(negedge clk) begin
        if (rst) begin
            rq.delete();
            mem_rvalid = 1'b0;
            mem_rdata  = 16'h0000;
        end else if (rq.size() > 0) begin
            logic [15:0] a;
            a = rq.pop_front();
            mem_rvalid = 1'b1;
            mem_rdata  = mem[a[15:1]];
        end else begin
            mem_rvalid = 1'b0;
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected data=%h hit=%b required no response", rsp_rdata, rsp_hit);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rsp_rdata !== e.data || rsp_hit !== e.hit) begin
                    failures++;
                    $display("FAIL rsp data=%h hit=%b required data=%h hit=%b", rsp_rdata, rsp_hit, e.data, e.hit);
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                         input logic [15:0] ed, input logic eh, output int lat);
        exp_t e;
        int k;
        lat = -1;
        k = 0;
        while (req_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (req_ready !== 1'b1) begin
            checks++; failures++;
            $display("FAIL req_ready_wait got=%b required 1", req_ready);
            return;
        end
        e.data = ed;
        e.hit  = eh;
        exp_q.push_back(e);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (n == 1) req_valid = 1'b0;
            if (rsp_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) begin
            checks++; failures++;
            $display("FAIL rsp_timeout addr=%h got no rsp_valid required one", addr);
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_hit !== 1'b0 || rsp_rdata !== 16'h0000 ||
            mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0 || mem_addr !== 16'h0000 || mem_wdata !== 16'h0000) begin
            failures++;
            $display("FAIL reset_outputs got ready=%b rv=%b hit=%b rd=%h rden=%b wren=%b ma=%h mw=%h required 1,0,0,0,0,0,0,0",
                     req_ready, rsp_valid, rsp_hit, rsp_rdata, mem_rd_en, mem_wr_en, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_cold_fill();
        int lat, base;
        base = rd_count;
        rd_log.delete();
        issue(1'b0, 16'h0412, 16'h0000, 16'h0412, 1'b0, lat);
        checks++;
        if (rd_count - base != 8) begin
            failures++;
            $display("FAIL fill_reads got=%0d required 8", rd_count - base);
        end
        for (int i = 0; i < 8 && i < rd_log.size(); i++) begin
            checks++;
            if (rd_log[i] !== 16'h0410 + 16'(2 * i)) begin
                failures++;
                $display("FAIL fill_addr[%0d] got=%h required %h", i, rd_log[i], 16'h0410 + 16'(2 * i));
            end
        end
        issue(1'b0, 16'h0414, 16'h0000, 16'h0414, 1'b1, lat);
        checks++;
        if (lat != 2) begin
            failures++;
            $display("FAIL hit_latency got=%0d required 2", lat);
        end
    endtask

    task automatic test_conflict();
        logic [15:0] addrs [6];
        logic        hits  [6];
        int lat;
        addrs = '{16'h0410, 16'h0810, 16'h0410, 16'h0C10, 16'h0410, 16'h0810};
        hits  = '{1'b1,     1'b0,     1'b1,     1'b0,     1'b1,     1'b0};
        for (int i = 0; i < 6; i++) begin
            issue(1'b0, addrs[i], 16'h0000, addrs[i], hits[i], lat);
        end
    endtask

    task automatic test_store_hit();
        int lat, base;
        base = wr_count;
        issue(1'b1, 16'h0416, 16'hBEEF, 16'h0000, 1'b1, lat);
        checks++;
        if (wr_count - base != 1 || last_wr_addr !== 16'h0416 || last_wr_data !== 16'hBEEF) begin
            failures++;
            $display("FAIL store_hit_mem got n=%0d a=%h d=%h required 1 0416 beef", wr_count - base, last_wr_addr, last_wr_data);
        end
        issue(1'b0, 16'h0416, 16'h0000, 16'hBEEF, 1'b1, lat);
    endtask

    task automatic test_store_miss();
        int lat, rbase, wbase;
        rbase = rd_count;
        wbase = wr_count;
        issue(1'b1, 16'h2000, 16'h1234, 16'h0000, 1'b0, lat);
        checks++;
        if (rd_count != rbase || wr_count - wbase != 1 || last_wr_addr !== 16'h2000 || last_wr_data !== 16'h1234) begin
            failures++;
            $display("FAIL store_miss_mem got reads=%0d writes=%0d a=%h d=%h required 0 1 2000 1234",
                     rd_count - rbase, wr_count - wbase, last_wr_addr, last_wr_data);
        end
        issue(1'b0, 16'h2000, 16'h0000, 16'h1234, 1'b0, lat);
        checks++;
        if (rd_count - rbase != 8) begin
            failures++;
            $display("FAIL store_miss_refill got=%0d required 8", rd_count - rbase);
        end
    endtask

    task automatic test_stall_and_abort();
        int lat, base, k;
        base = rd_count;
        fork
            issue(1'b0, 16'h3024, 16'h0000, 16'h3024, 1'b0, lat);
            begin
                k = 0;
                while (rd_count - base < 3 && k < 100) begin @(negedge clk); k++; end
                mem_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    checks++;
                    if (req_ready !== 1'b0) begin
                        failures++;
                        $display("FAIL stall_ready cycle %0d got=%b required 0", i, req_ready);
                    end
                end
                mem_ready = 1'b1;
            end
        join
        checks++;
        if (rd_count - base != 8) begin
            failures++;
            $display("FAIL stall_reads got=%0d required 8", rd_count - base);
        end
        issue(1'b0, 16'h302E, 16'h0000, 16'h302E, 1'b1, lat);
        issue(1'b0, 16'h3020, 16'h0000, 16'h3020, 1'b1, lat);

        // Abort a fill with reset after four words have landed.
        k = 0;
        while (req_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        base = ret_count;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h4040;
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (ret_count - base < 4 && k < 100) begin @(negedge clk); k++; end
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || mem_rd_en !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_reset got ready=%b rden=%b rv=%b required 1 0 0", req_ready, mem_rd_en, rsp_valid);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        issue(1'b0, 16'h4040, 16'h0000, 16'h4040, 1'b0, lat);
        // Reset invalidated everything, including earlier resident lines.
        issue(1'b0, 16'h0410, 16'h0000, 16'h0410, 1'b0, lat);
    endtask

`ifdef CACHE_STATS_EN
    task automatic test_stats();
        int lat;
        do_reset();
        issue(1'b0, 16'h0412, 16'h0000, 16'h0412, 1'b0, lat);
        issue(1'b0, 16'h0414, 16'h0000, 16'h0414, 1'b1, lat);
        @(negedge clk);
        checks++;
        if (stat_misses !== 32'd1 || stat_hits !== 32'd1) begin
            failures++;
            $display("FAIL stats got hits=%0d misses=%0d required 1 1", stat_hits, stat_misses);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'(2 * i);
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_cold_fill();
        test_conflict();
        test_store_hit();
        test_store_miss();
        test_stall_and_abort();
`ifdef CACHE_STATS_EN
        test_stats();
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_rsp got=%0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
